// File: rtl/insn_pkg.sv
// Shared definitions for the instruction loader: instruction field layout,
// loader FSM state encoding, default memory depth and a word-legality helper.
// The field layout mirrors the single-cycle core's instruction decoder.
package insn_pkg;

  // Default instruction-memory depth in 32-bit words.
  localparam int DEPTH = 32;

  // Instruction field positions (msb/lsb).
  localparam int SRC1_MSB  = 4;
  localparam int SRC1_LSB  = 0;
  localparam int SRC2_MSB  = 9;
  localparam int SRC2_LSB  = 5;
  localparam int DST_MSB   = 14;
  localparam int DST_LSB   = 10;
  localparam int IMM_MSB   = 19;
  localparam int IMM_LSB   = 15;
  localparam int M_W_BIT   = 20;
  localparam int R_W_BIT   = 21;
  localparam int OP_BIT    = 22;
  localparam int R_SRC_BIT = 23;
  localparam int RSVD_MSB  = 31;
  localparam int RSVD_LSB  = 24;

  // Same layout as a packed struct, msb first.
  typedef struct packed {
    logic [7:0] rsvd;
    logic       r_src;
    logic       op;
    logic       r_w;
    logic       m_w;
    logic [4:0] imm;
    logic [4:0] dst;
    logic [4:0] src2;
    logic [4:0] src1;
  } insn_t;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // A word is encodable by the core only if its reserved byte is zero.
  function automatic logic insn_legal(input logic [31:0] w);
    insn_t f;
    f = insn_t'(w);
    return (f.rsvd == 8'h00) && (w[RSVD_MSB:RSVD_LSB] == 8'h00);
  endfunction

endpackage

// File: rtl/insn_loader_byte_packer.sv
// Byte packer: assembles 4 bytes into a little-endian word and keeps a running
// XOR of every byte taken since the last clear. Word is registered; o_full
// flags that the next accepted byte completes the current word.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [7:0]  o_xor,
  output logic        o_full
);

  logic [31:0] r_word;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_xor;

  // Lane shift-in, byte counter and checksum accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word     <= 32'h0;
      r_byte_idx <= 2'd0;
      r_xor      <= 8'h0;
    end else if (i_clr) begin
      r_byte_idx <= 2'd0;
      r_xor      <= 8'h0;
    end else if (i_en) begin
      r_word[{r_byte_idx, 3'b000} +: 8] <= i_byte;
      r_byte_idx                        <= r_byte_idx + 2'd1;
      r_xor                             <= r_xor ^ i_byte;
    end
  end

  assign o_word = r_word;
  assign o_xor  = r_xor;
  assign o_full = (r_byte_idx == 2'd3);

endmodule

// File: rtl/insn_loader.sv
// Program loader: parses count/payload/checksum frames and writes words to imem.
// Latency: write strobe one cycle after a word's 4th byte; done/err one cycle after FINISH.
// Backpressure: in_ready drops for the WRITE and FINISH cycles; in_valid low stalls freely.
module insn_loader #(
  parameter int DEPTH  = insn_pkg::DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_w_v,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  import insn_pkg::*;

  // Word index covers 0..DEPTH-1; the count register must also hold DEPTH.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NW-1:0]   r_n;
  logic [IW-1:0]   r_word_idx;
  logic            r_hold;
  logic            r_done;
  logic            r_err;
  logic            r_bad_word;
  logic            r_csum_ok;

  logic            w_ready;
  logic            w_acc;
  logic [31:0]     w_cnt_ext;
  logic            w_cnt_legal;
  logic            w_cnt_take;
  logic            w_cnt_bad;
  logic            w_data_take;
  logic            w_chk_take;
  logic            w_last_word;
  logic [31:0]     w_pk_word;
  logic [7:0]      w_pk_xor;
  logic            w_pk_full;

  // in_ready is a pure state decode, forced low while reset is held.
  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_CHECK);
  assign in_ready = w_ready & ~rst;
  assign w_acc    = in_valid & in_ready;

  // Count byte must be in 1..DEPTH.
  assign w_cnt_ext   = {24'd0, in_data};
  assign w_cnt_legal = (w_cnt_ext != 32'd0) && (w_cnt_ext <= 32'(DEPTH));

  assign w_cnt_take  = w_acc && (r_state == ST_IDLE) && w_cnt_legal;
  assign w_cnt_bad   = w_acc && (r_state == ST_IDLE) && !w_cnt_legal;
  assign w_data_take = w_acc && (r_state == ST_DATA);
  assign w_chk_take  = w_acc && (r_state == ST_CHECK);

  // Index of the word being written is the last one of the frame.
  assign w_last_word = ((NW'(r_word_idx) + NW'(1)) == r_n);

  byte_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_take),
    .i_en   (w_data_take),
    .i_byte (in_data),
    .o_word (w_pk_word),
    .o_xor  (w_pk_xor),
    .o_full (w_pk_full)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_cnt_take) w_state_nxt = ST_DATA;
      ST_DATA:   if (w_data_take && w_pk_full) w_state_nxt = ST_WRITE;
      ST_WRITE:  w_state_nxt = w_last_word ? ST_CHECK : ST_DATA;
      ST_CHECK:  if (w_chk_take) w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame bookkeeping: count, word index, sticky encoding flag, status levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n        <= '0;
      r_word_idx <= '0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_bad_word <= 1'b0;
      r_csum_ok  <= 1'b0;
    end else begin
      if (w_cnt_take) begin
        r_n        <= in_data[NW-1:0];
        r_word_idx <= '0;
        r_bad_word <= 1'b0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_hold     <= 1'b1;
      end
      if (w_cnt_bad) begin
        r_err  <= 1'b1;
        r_done <= 1'b0;
      end
      if (r_state == ST_WRITE) begin
        // The write always happens; an illegal encoding only poisons the frame.
        if (!insn_legal(w_pk_word)) begin
          r_bad_word <= 1'b1;
        end
        // Hold the index at N-1 after the last word so it never wraps.
        if (!w_last_word) begin
          r_word_idx <= r_word_idx + IW'(1);
        end
      end
      if (w_chk_take) begin
        r_csum_ok <= (in_data == w_pk_xor);
      end
      if (r_state == ST_FINISH) begin
        r_done <= r_csum_ok && !r_bad_word;
        r_err  <= !(r_csum_ok && !r_bad_word);
        r_hold <= 1'b0;
      end
    end
  end

  assign mem_w    = (r_state == ST_WRITE);
  assign mem_addr = ADDR_W'(r_word_idx);
  assign mem_w_v  = w_pk_word;
  assign cpu_hold = r_hold;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_insn_loader.sv
// Bench for insn_loader: directed and random frames against a byte-stream
// reference model; every cycle's outputs are compared at the falling edge.
module tb_insn_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_w;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_w_v;
  logic              cpu_hold;
  logic              done;
  logic              err;

  insn_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_w(mem_w), .mem_addr(mem_addr), .mem_w_v(mem_w_v),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Parses the accepted byte stream; expected outputs describe the cycle that
  // follows each rising edge.
  int          cyc = 0;
  int          m_phase = 0;          // 0 = expect count, 1 = payload, 2 = checksum
  int          m_n = 0, m_widx = 0, m_bidx = 0;
  logic [31:0] m_word = 0;
  logic [7:0]  m_xor = 0, last_xor = 0;
  logic        m_bad = 0;
  int          fin_due = -1;
  logic        fin_ok = 0;
  int          m_cnt_cyc = 0;
  logic        e_ready = 1'b0, e_mw = 1'b0, e_hold = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = 0, e_data = 0;
  int          n_writes = 0;
  logic [31:0] last_addr = 0, last_data = 0;

  always @(posedge clk) begin : model
    logic [7:0] b;
    cyc++;
    if (rst) begin
      m_phase = 0; fin_due = -1; m_bidx = 0; m_widx = 0;
      e_ready = 1'b1; e_mw = 1'b0; e_hold = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      e_mw    = 1'b0;
      e_ready = 1'b1;
      if (fin_due == cyc) begin
        e_done  = fin_ok;
        e_err   = !fin_ok;
        e_hold  = 1'b0;
        fin_due = -1;
      end
      if (in_valid && in_ready) begin
        b = in_data;
        if (m_phase == 0) begin
          if (b >= 1 && int'(b) <= DEPTH) begin
            m_n = int'(b); m_widx = 0; m_bidx = 0; m_xor = 8'h00; m_bad = 1'b0;
            e_done = 1'b0; e_err = 1'b0; e_hold = 1'b1; m_phase = 1; m_cnt_cyc = cyc;
          end else begin
            e_err = 1'b1; e_done = 1'b0;
          end
        end else if (m_phase == 1) begin
          m_word[8*m_bidx +: 8] = b;
          m_xor = m_xor ^ b;
          m_bidx++;
          if (m_bidx == 4) begin
            e_mw = 1'b1; e_addr = m_widx; e_data = m_word; e_ready = 1'b0;
            if (m_word[31:24] != 8'h00) m_bad = 1'b1;
            m_widx++; m_bidx = 0;
            if (m_widx == m_n) m_phase = 2;
          end
        end else begin
          fin_ok   = (b == m_xor) && !m_bad;
          last_xor = m_xor;
          fin_due  = cyc + 1;
          e_ready  = 1'b0;
          m_phase  = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_w", mem_w, 0);
      chk("rst_cpu_hold", cpu_hold, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_w_v", mem_w_v, 0);
    end else begin
      chk("in_ready", in_ready, e_ready);
      chk("mem_w", mem_w, e_mw);
      chk("cpu_hold", cpu_hold, e_hold);
      chk("done", done, e_done);
      chk("err", err, e_err);
      if (e_mw) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_w_v", mem_w_v, e_data);
      end
      if (mem_w === 1'b1) begin
        n_writes++;
        last_addr = mem_addr;
        last_data = mem_w_v;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] fw [32];

  function automatic int gap_of(input int gmode);
    if (gmode == 1) return 1;
    if (gmode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  // Called and returns just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    acc = 1'b0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(posedge clk);
      acc = in_ready;
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++; n_bad++;
      $display("FAIL send_byte_timeout: byte %h not accepted within 200 cycles", b);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] csum_flip, input int gmode);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    send_byte(8'(n), gap_of(gmode));
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = fw[w][8*k +: 8];
        x = x ^ b;
        send_byte(b, gap_of(gmode));
      end
    end
    send_byte(x ^ csum_flip, gap_of(gmode));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic fill_legal(input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = $urandom();
      fw[i] = {8'h00, t[23:0]};
    end
  endtask

  int w0;

  initial begin : main
    logic [31:0] t;
    int n;
    logic [7:0] flip;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(1);
    chk("post_rst_in_ready", in_ready, 1);

    // Single-word frame with hand-computed checksum.
    w0 = n_writes;
    fw[0] = 32'h002C0403;
    send_frame(1, 8'h00, 0);
    chk("f1_model_xor", last_xor, 8'h2B);
    wait_cycles(1);
    chk("f1_done", done, 1);
    chk("f1_err", err, 0);
    chk("f1_writes", n_writes - w0, 1);
    chk("f1_addr", last_addr, 0);
    chk("f1_data", last_data, 32'h002C0403);
    chk("f1_hold", cpu_hold, 0);

    // Full-depth back-to-back frame: best-case timing.
    w0 = n_writes;
    fill_legal(32);
    send_frame(32, 8'h00, 0);
    chk("f32_latency", cyc - m_cnt_cyc, 5 * 32 + 1);
    wait_cycles(1);
    chk("f32_done", done, 1);
    chk("f32_writes", n_writes - w0, 32);
    chk("f32_last_addr", last_addr, 31);
    chk("f32_last_data", last_data, fw[31]);

    // Illegal counts 0 and DEPTH+1.
    w0 = n_writes;
    send_byte(8'd0, 0);
    chk("cnt0_err", err, 1);
    chk("cnt0_done", done, 0);
    chk("cnt0_hold", cpu_hold, 0);
    send_byte(8'd33, 0);
    chk("cnt33_err", err, 1);
    chk("cnt33_hold", cpu_hold, 0);
    wait_cycles(2);
    chk("cnt_bad_writes", n_writes - w0, 0);

    // Checksum off by one bit.
    w0 = n_writes;
    fill_legal(4);
    send_frame(4, 8'h01, 0);
    wait_cycles(1);
    chk("badcs_writes", n_writes - w0, 4);
    chk("badcs_err", err, 1);
    chk("badcs_done", done, 0);

    // Reserved byte set, correct checksum.
    w0 = n_writes;
    fw[0] = 32'h01000000;
    send_frame(1, 8'h00, 0);
    wait_cycles(1);
    chk("rsvd_writes", n_writes - w0, 1);
    chk("rsvd_data", last_data, 32'h01000000);
    chk("rsvd_err", err, 1);
    chk("rsvd_done", done, 0);

    // in_valid toggling every other cycle.
    w0 = n_writes;
    fill_legal(3);
    send_frame(3, 8'h00, 1);
    wait_cycles(1);
    chk("stall_writes", n_writes - w0, 3);
    chk("stall_done", done, 1);

    // Reset after 6 payload bytes of a 3-word frame.
    fill_legal(3);
    send_byte(8'd3, 0);
    for (int i = 0; i < 6; i++) send_byte(fw[i / 4][8*(i % 4) +: 8], 0);
    chk("pre_rst_hold", cpu_hold, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_hold", cpu_hold, 0);
    wait_cycles(2);
    rst = 1'b0;
    w0 = n_writes;
    wait_cycles(10);
    chk("post_rst_writes", n_writes - w0, 0);
    chk("post_rst_hold", cpu_hold, 0);
    chk("post_rst_done", done, 0);

    // Random frames.
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        send_byte(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(33, 255)), gap_of(2));
      end else begin
        n = int'($urandom_range(1, 8));
        for (int i = 0; i < n; i++) begin
          t = $urandom();
          fw[i] = ($urandom_range(0, 5) == 0) ? t : {8'h00, t[23:0]};
        end
        flip = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        send_frame(n, flip, 2);
      end
      wait_cycles(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
